float_vector_serializer: RTL
============================

# float_vector_serializer

Converts a flattened IEEE-754 single-precision vector, in the packed `32*i +: 32` lane layout the neural layers produce, into a stream of one 32-bit word per beat with valid/ready handshaking. It sits at the output of the last `NeuralLayerSeq`/`NeuralLayerPar` stage and feeds result words to a host or memory writer, one at a time. It is the write-side counterpart of the memory-to-vector packing used to load layer inputs. An optional argmax unit reports the index of the largest element once the stream completes.

## Interface
- `SIZE`, 15: number of 32-bit elements in the vector; ≥ 1.
- `IDX_W`, `$clog2(SIZE)` (min 1): width of the index outputs.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in` in 32*SIZE: packed vector; element i is `in[32*i +: 32]`.
- `in_valid` in 1: `in` is valid.
- `in_ready` out 1: block can capture a vector.
- `out_data` out 32: current element.
- `out_index` out IDX_W: index of `out_data`.
- `out_valid` out 1: `out_data` and `out_index` are valid.
- `out_ready` in 1: the consumer accepts the beat.
- `out_last` out 1: the current beat is element SIZE-1.
- `argmax_index` out IDX_W: index of the maximum element (only with ARGMAX_EN).
- `argmax_valid` out 1: `argmax_index` is valid (only with ARGMAX_EN).

## Operation
- FSM has two states, IDLE and SEND.
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` is high, the block captures the whole of `in` into an internal buffer, sets counter = 0, and goes to SEND.
- **SEND**
  - `in_ready` = 0.
  - `out_valid` = 1, `out_data` = buffer[counter], `out_index` = counter, `out_last` = (counter == SIZE-1).
  - A beat completes when `out_valid && out_ready` at a rising edge.
  - A non-last beat increments the counter.
  - The last beat returns the FSM to IDLE.
- Changes on `in` while in SEND have no effect, because the buffer is held.
- Words pass through bit-exact. NaN, infinities and denormals are not altered.
- **Reset**
  - Asynchronous, valid at any point including mid-stream.
  - The stream is discarded and the FSM goes to IDLE.
  - Output values during reset: `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `argmax_index`=0, `argmax_valid`=0.
  - `in_ready` is 0 while `rst` is high and 1 from the first edge after release.
- **SIZE = 1:** every beat has `out_last`=1.

## Timing
- Capture edge to first beat: `out_valid` rises at the capture edge (registered), so word 0 is presented in the next cycle.
- Throughput: one word per cycle while `out_ready` is held high. A full vector takes SIZE cycles in SEND.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
- Turnaround:
  - After the last beat, the block is in IDLE for at least one cycle (`in_ready`=1) before the next capture.
  - The minimum period between vectors is SIZE+1 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- Macro: `FLOAT_VECTOR_SERIALIZER_ARGMAX_EN`.
- **Defined:**
  - The candidate is initialised to element 0 and its index at capture. `argmax_valid` clears at capture.
  - On each accepted beat with index > 0, the candidate is replaced only if the word is strictly greater than it, using IEEE order.
  - Compare rules: any comparison involving NaN is false. +0 and -0 are equal. On a tie, the lower index is kept.
  - On the edge that accepts the last beat, `argmax_index` and `argmax_valid`=1 are updated. They hold until the next capture or reset.
- **Undefined:** no compare logic is instantiated. `argmax_index` and `argmax_valid` are tied to 0.

## Structure
- Shared package `nn_pkg` holds:
  - `FLOAT_W = 32`
  - the float word typedef
  - field constants: sign bit 31, exponent 30:23, mantissa 22:0
  - the quiet-NaN constant `32'h7FC00000`
- Sub-module `float_greater` is combinational and computes a > b:
  - If either input is NaN, the result is false.
  - If both magnitudes are zero, the result is false.
  - If the signs differ, the positive operand is greater.
  - Both positive: compare `a[30:0] > b[30:0]`.
  - Both negative: compare `a[30:0] < b[30:0]`.
- The buffer, counter and FSM stay in the top module.

## Test plan
- **Basic stream.** SIZE=4, `in` = {0x40400000, 0x40000000, 0xBF800000, 0x3F800000} (elements 3..0), `out_ready`=1.
  - Expect beats 0..3 = 0x3F800000, 0xBF800000, 0x40000000, 0x40400000 on 4 consecutive cycles.
  - Expect `out_last` only on index 3, and `in_ready` back to 1 on the next cycle.
- **Backpressure.** Same vector, `out_ready` low for 3 cycles at index 1.
  - Expect `out_data`=0xBF800000 and `out_index`=1 held stable. The stream then resumes with no loss or duplication.
- **Reset mid-stream.** Assert `rst` at index 2.
  - Expect `out_valid`=0 immediately (asynchronous). After release, a new capture restarts at index 0 with the new data.
- **Argmax (macro on).** Elements {1.0, 3.0, -2.0, 3.0} = {0x3F800000, 0x40400000, 0xC0000000, 0x40400000}.
  - Expect `argmax_index`=1 (the tie keeps the lower index) and `argmax_valid` high after the last beat.
- **Argmax with NaN and signed zero (macro on).** Elements {0x80000000, 0x00000000, 0x7FC00000, 0xBF800000}.
  - Expect `argmax_index`=0.
- **Input ignored while busy.** With `in_valid` held high throughout and `in` changed during SEND:
  - the emitted words match the first captured vector;
  - the second capture happens only after the IDLE cycle.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared float-word types and IEEE-754 field constants for the neural datapath.
package nn_pkg;
  localparam int FLOAT_W  = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  typedef logic [FLOAT_W-1:0] float_t;

  localparam float_t QNAN = 32'h7FC00000;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

  // NaN: exponent all ones (as in QNAN) with a non-zero mantissa.
  function automatic logic is_nan(input float_t f);
    return (f[EXP_MSB:EXP_LSB] == QNAN[EXP_MSB:EXP_LSB])
        && (|f[MAN_MSB:0]);
  endfunction

  function automatic logic is_zero(input float_t f);
    return ~|f[EXP_MSB:0];
  endfunction
endpackage

// File: rtl/float_greater.sv
// Combinational IEEE-754 single-precision a > b.
// NaN compares false; +0 and -0 are equal.
module float_greater
  import nn_pkg::*;
(
  input  float_t a,
  input  float_t b,
  output logic   gt
);
  always_comb begin
    gt = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      gt = 1'b0;
    end else if (is_zero(a) && is_zero(b)) begin
      gt = 1'b0;
    end else if (a[SIGN_BIT] != b[SIGN_BIT]) begin
      gt = ~a[SIGN_BIT];
    end else if (!a[SIGN_BIT]) begin
      gt = a[EXP_MSB:0] > b[EXP_MSB:0];
    end else begin
      gt = a[EXP_MSB:0] < b[EXP_MSB:0];
    end
  end
endmodule

// File: rtl/float_vector_serializer.sv
// Streams a packed float vector one word per beat over valid/ready.
// Optional argmax tracker: FLOAT_VECTOR_SERIALIZER_ARGMAX_EN.
module float_vector_serializer
  import nn_pkg::*;
#(
  parameter int SIZE  = 15,
  parameter int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*SIZE-1:0]    in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLOAT_W-1:0]    out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [IDX_W-1:0]      argmax_index,
  output logic                  argmax_valid
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  ser_state_t       state;
  float_t           vec_q [SIZE];
  logic [IDX_W-1:0] cnt;
  logic             capture;
  logic             beat;

  // in_ready doubles as the post-reset guard: low until the first edge.
  assign capture   = (state == IDLE) && in_ready && in_valid;
  assign beat      = out_valid && out_ready;
  assign out_index = cnt;
  assign out_data  = out_valid ? vec_q[cnt] : '0;

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < SIZE; i++) begin
        vec_q[i] <= in[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= !capture;
          if (capture) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_last  <= (SIZE == 1);
            cnt       <= '0;
          end
        end
        SEND: begin
          if (beat) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt      <= cnt + 1'b1;
              out_last <= (cnt == LAST - 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLOAT_VECTOR_SERIALIZER_ARGMAX_EN
  float_t           cand;
  logic [IDX_W-1:0] cand_idx;
  logic             gt;
  logic             take;

  float_greater u_gt (
    .a  (out_data),
    .b  (cand),
    .gt (gt)
  );

  assign take = gt && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand         <= '0;
      cand_idx     <= '0;
      argmax_index <= '0;
      argmax_valid <= 1'b0;
    end else if (capture) begin
      cand         <= in[FLOAT_W-1:0];
      cand_idx     <= '0;
      argmax_valid <= 1'b0;
    end else if (beat) begin
      if (take) begin
        cand     <= out_data;
        cand_idx <= cnt;
      end
      if (out_last) begin
        argmax_index <= take ? cnt : cand_idx;
        argmax_valid <= 1'b1;
      end
    end
  end
`else
  assign argmax_index = '0;
  assign argmax_valid = 1'b0;
`endif
endmodule
